// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic_modules library: default widths and
// the divider state encoding.
package arith_pkg;

   localparam int unsigned DIV_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, then do a trial
// subtraction with a ripple adder (inverted divisor, carry-in 1).
module div_step
   import arith_pkg::*;
#(
   parameter int unsigned N = DIV_W
) (
   input  logic [N:0]   r,
   input  logic         shift_in,
   input  logic [N-1:0] d,
   output logic [N:0]   r_next,
   output logic         q_bit
);

   logic [N:0] r_sh;
   logic [N:0] d_inv;
   logic [N:0] trial;

   assign r_sh  = {r[N-1:0], shift_in};
   assign d_inv = ~{1'b0, d};

   // (N+1)-bit ripple-carry adder computing r_sh - d
   always_comb begin
      logic c;
      c     = 1'b1;
      trial = '0;
      for (int unsigned i = 0; i <= N; i++) begin
         trial[i] = r_sh[i] ^ d_inv[i] ^ c;
         c        = (r_sh[i] & d_inv[i]) | (c & (r_sh[i] ^ d_inv[i]));
      end
   end

   // A set R[N] means the shifted value overflowed N+1 bits and is surely >= d
   assign q_bit  = r[N] | ~trial[N];
   assign r_next = q_bit ? trial : r_sh;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with a start/busy/done handshake;
// one trial subtraction per clock, N iterations per divide.
module seq_divider
   import arith_pkg::*;
#(
   parameter int unsigned N = DIV_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam int unsigned CW = $clog2(N) + 1;

   div_state_t   state, state_n;
   logic [N:0]   r, r_n;
   logic [N-1:0] q, q_n;
   logic [N-1:0] d, d_n;
   logic [CW-1:0] count, count_n;
   logic         busy_n, done_n, dbz_n;
   logic [N-1:0] quotient_n, remainder_n;

   logic [N:0]   r_step;
   logic         q_bit;

   div_step #(.N(N)) u_step (
      .r        (r),
      .shift_in (q[N-1]),
      .d        (d),
      .r_next   (r_step),
      .q_bit    (q_bit)
   );

   // Next-state and next-output logic; FIN accepts start exactly like IDLE
   always_comb begin
      state_n     = state;
      r_n         = r;
      q_n         = q;
      d_n         = d;
      count_n     = count;
      done_n      = 1'b0;
      quotient_n  = quotient;
      remainder_n = remainder;
      dbz_n       = div_by_zero;

      case (state)
         RUN: begin
            r_n     = r_step;
            q_n     = {q[N-2:0], q_bit};
            count_n = count + CW'(1);
            if (count == CW'(N - 1)) begin
               state_n     = FIN;
               done_n      = 1'b1;
               quotient_n  = {q[N-2:0], q_bit};
               remainder_n = r_step[N-1:0];
            end
         end
         default: begin
            state_n = IDLE;
            if (start) begin
               if (divisor != '0) begin
                  state_n = RUN;
                  r_n     = '0;
                  q_n     = dividend;
                  d_n     = divisor;
                  count_n = '0;
                  dbz_n   = 1'b0;
               end else begin
                  state_n     = FIN;
                  done_n      = 1'b1;
                  quotient_n  = '1;
                  remainder_n = dividend;
                  dbz_n       = 1'b1;
               end
            end
         end
      endcase

      busy_n = (state_n == RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         r           <= '0;
         q           <= '0;
         d           <= '0;
         count       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         state       <= state_n;
         r           <= r_n;
         q           <= q_n;
         d           <= d_n;
         count       <= count_n;
         busy        <= busy_n;
         done        <= done_n;
         quotient    <= quotient_n;
         remainder   <= remainder_n;
         div_by_zero <= dbz_n;
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider against a / and % scoreboard,
// including latency, busy width, back-to-back starts and mid-run reset.
module tb_seq_divider;

   localparam int unsigned N = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [N-1:0] dividend = '0;
   logic [N-1:0] divisor = '0;
   logic         busy, done, div_by_zero;
   logic [N-1:0] quotient, remainder;

   seq_divider #(.N(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         dbz;
      int           lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Drive a start request and record the expected outcome
   task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
      exp_t e;
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      if (b == '0) begin
         e.q   = '1;
         e.r   = a;
         e.dbz = 1'b1;
         e.lat = 1;
      end else begin
         e.q   = a / b;
         e.r   = a % b;
         e.dbz = 1'b0;
         e.lat = N + 1;
      end
      sb.push_back(e);
   endtask

   task automatic wait_done(input bit drop, input int cyc0, output int cyc, output int busy_cnt);
      cyc      = cyc0;
      busy_cnt = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (drop) start = 1'b0;
         if (busy) busy_cnt++;
      end while (!done && cyc < 200);
   endtask

   task automatic complete(input bit drop, input int cyc0, input string tag, output int busy_cnt);
      int   cyc;
      exp_t e;
      wait_done(drop, cyc0, cyc, busy_cnt);
      check({tag, " done"}, 32'(done), 32'd1);
      if (sb.size() == 0) begin
         check({tag, " scoreboard"}, 32'(sb.size()), 32'd1);
         return;
      end
      e = sb.pop_front();
      check({tag, " quotient"}, quotient, e.q);
      check({tag, " remainder"}, remainder, e.r);
      check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(e.dbz));
      check({tag, " latency"}, 32'(cyc), 32'(e.lat));
   endtask

   initial begin
      int           bc;
      logic [N-1:0] a, b;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst quotient", quotient, 32'd0);
      check("rst remainder", remainder, 32'd0);
      check("rst dbz", 32'(div_by_zero), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 100 / 7 with latency, busy width and one-cycle done
      issue(32'd100, 32'd7);
      complete(1'b1, 0, "100/7", bc);
      check("100/7 busy cycles", 32'(bc), 32'd32);
      check("100/7 busy at done", 32'(busy), 32'd0);
      @(negedge clk);
      check("100/7 done pulse", 32'(done), 32'd0);
      check("100/7 held quotient", quotient, 32'd14);

      issue(32'd5, 32'd9);
      complete(1'b1, 0, "5/9", bc);
      @(negedge clk);
      issue(32'hFFFF_FFFF, 32'd1);
      complete(1'b1, 0, "max/1", bc);
      @(negedge clk);
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      complete(1'b1, 0, "max/max", bc);
      @(negedge clk);

      // Divide by zero, then a normal divide clears the flag
      issue(32'd1234, 32'd0);
      complete(1'b1, 0, "1234/0", bc);
      @(negedge clk);
      check("1234/0 held dbz", 32'(div_by_zero), 32'd1);
      issue(32'd9, 32'd3);
      complete(1'b1, 0, "9/3", bc);
      @(negedge clk);

      // Start during RUN ignored, then held through FIN is accepted
      issue(32'd50, 32'd5);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      start    = 1'b1;
      dividend = 32'd77;
      divisor  = 32'd2;
      complete(1'b0, 10, "50/5 run-start", bc);
      issue(32'd77, 32'd2);
      complete(1'b1, 0, "77/2 back-to-back", bc);
      @(negedge clk);

      // Asynchronous reset mid-run
      issue(32'd1000, 32'd3);
      @(negedge clk);
      start = 1'b0;
      repeat (16) @(negedge clk);
      check("pre-reset busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid-rst busy", 32'(busy), 32'd0);
      check("mid-rst done", 32'(done), 32'd0);
      check("mid-rst quotient", quotient, 32'd0);
      check("mid-rst remainder", remainder, 32'd0);
      check("mid-rst dbz", 32'(div_by_zero), 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post-rst idle", 32'(busy), 32'd0);
      issue(32'd1000, 32'd3);
      complete(1'b1, 0, "1000/3 after reset", bc);
      @(negedge clk);

      // Random operands, a quarter of them with a zero divisor
      for (int i = 0; i < 1000; i++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = '0;
            1:       b = N'($urandom_range(1, 15));
            2:       b = $urandom;
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         issue(a, b);
         complete(1'b1, 0, "random", bc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
